fetch_req_queue: RTL and testbench

//  Decoupling FIFO between the PC generator and the ICache request port.
//  - Captures each valid fetch PC, buffers up to DEPTH entries, issues them in order to the ICache.
//  - Drives the PC stall back to the PC generator.
//  - Tags every request with a redirect epoch, so stale responses after a flush are dropped downstream.

---
 rtl/fetch_req_queue_if.sv | 26 ++
 rtl/fetch_req_queue.sv | 88 ++++++++
 tb/tb_fetch_req_queue.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_req_queue_if.sv
// Fetch request bundle between PC generator, fetch queue and ICache request port.
// master: PC generator / ICache side; slave: the queue itself.
interface fetch_req_queue_if #(
    parameter int ADDR_W = 32,
    parameter int PTR_W  = 2
);
    logic              PcAble;
    logic [ADDR_W-1:0] PcDate;
    logic              QueFlush;
    logic              QueStop;
    logic              IcReqValid;
    logic [ADDR_W-1:0] IcReqAddr;
    logic              IcReqEpoch;
    logic              IcReqReady;
    logic [PTR_W:0]    QueCount;

    modport master (
        output PcAble, PcDate, QueFlush, IcReqReady,
        input  QueStop, IcReqValid, IcReqAddr, IcReqEpoch, QueCount
    );

    modport slave (
        input  PcAble, PcDate, QueFlush, IcReqReady,
        output QueStop, IcReqValid, IcReqAddr, IcReqEpoch, QueCount
    );
endinterface

// File: rtl/fetch_req_queue.sv
// In-order fetch PC queue feeding the ICache, with 1-bit redirect epoch tagging.
// Define FETCH_REQ_BYPASS_EN for a zero-latency path from PcDate when the queue is empty.
module fetch_req_queue #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2
) (
    input  logic              Clk,
    input  logic              Rest,
    fetch_req_queue_if.slave  bus
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] addr_mem  [DEPTH];
    logic              epoch_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             epoch_q, epoch_d;

    logic occupied, full, wr_en, rd_en;

    assign occupied = (count_q != '0);
    assign full     = (count_q == FULL_CNT);
    assign rd_en    = occupied & bus.IcReqReady & ~bus.QueFlush;

`ifdef FETCH_REQ_BYPASS_EN
    logic byp, byp_take;

    // An empty queue forwards the incoming PC; if the ICache takes it now it is never stored.
    assign byp      = ~occupied & bus.PcAble & ~bus.QueFlush;
    assign byp_take = byp & bus.IcReqReady;
    assign wr_en    = bus.PcAble & ~full & ~bus.QueFlush & ~byp_take;

    assign bus.IcReqValid = occupied | byp;
    assign bus.IcReqAddr  = occupied ? addr_mem[rd_ptr_q] : (byp ? bus.PcDate : '0);
    assign bus.IcReqEpoch = occupied ? epoch_mem[rd_ptr_q] : (byp & epoch_q);
`else
    assign wr_en = bus.PcAble & ~full & ~bus.QueFlush;

    assign bus.IcReqValid = occupied;
    assign bus.IcReqAddr  = occupied ? addr_mem[rd_ptr_q] : '0;
    assign bus.IcReqEpoch = occupied & epoch_mem[rd_ptr_q];
`endif

    assign bus.QueStop  = full;
    assign bus.QueCount = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        epoch_d  = epoch_q;
        if (bus.QueFlush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            epoch_d  = ~epoch_q;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
            rd_ptr_d = rd_ptr_q + PTR_W'(rd_en);
            count_d  = count_q + (PTR_W + 1)'(wr_en) - (PTR_W + 1)'(rd_en);
        end
    end

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            epoch_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            epoch_q  <= epoch_d;
        end
    end

    // Entry storage carries no reset; occupancy alone qualifies it.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            addr_mem[wr_ptr_q]  <= bus.PcDate;
            epoch_mem[wr_ptr_q] <= epoch_q;
        end
    end
endmodule

// File: tb/tb_fetch_req_queue.sv
// Directed bench for fetch_req_queue: queue-based reference model checked every cycle,
// plus literal expectations for reset, fill, drain, full-with-accept, flush and bypass.
module tb_fetch_req_queue;
    localparam int DEPTH = 4;

    logic Clk = 1'b0;
    logic Rest;

    always #5 Clk = ~Clk;

    fetch_req_queue_if #(.ADDR_W(32), .PTR_W(2)) bus();

    fetch_req_queue #(.ADDR_W(32), .DEPTH(DEPTH), .PTR_W(2)) dut (
        .Clk  (Clk),
        .Rest (Rest),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic        e;
    } ent_t;

    ent_t mq[$];
    logic m_ep = 1'b0;

    function automatic bit model_byp();
`ifdef FETCH_REQ_BYPASS_EN
        return (mq.size() == 0) && bus.PcAble && !bus.QueFlush;
`else
        return 1'b0;
`endif
    endfunction

    always @(negedge Rest) begin
        mq.delete();
        m_ep = 1'b0;
    end

    // Model state advance on each clock edge from the inputs applied during the cycle.
    always @(posedge Clk) begin
        if (Rest) begin
            automatic int  n     = mq.size();
            automatic bit  byp   = model_byp();
            automatic bit  vld   = (n != 0) || byp;
            automatic bit  stall = (n == DEPTH);
            automatic ent_t ne;
            if (bus.QueFlush) begin
                mq.delete();
                m_ep = ~m_ep;
            end else begin
                if (vld && bus.IcReqReady && n != 0) void'(mq.pop_front());
                if (bus.PcAble && !stall && !(byp && bus.IcReqReady)) begin
                    ne.a = bus.PcDate;
                    ne.e = m_ep;
                    mq.push_back(ne);
                end
            end
        end
    end

    always @(negedge Clk) begin
        automatic int n   = mq.size();
        automatic bit byp = model_byp();
        automatic bit vld = (n != 0) || byp;
        check("cyc_count", 32'(bus.QueCount), 32'(n));
        check("cyc_stop", 32'(bus.QueStop), 32'(n == DEPTH));
        check("cyc_valid", 32'(bus.IcReqValid), 32'(vld));
        if (vld) begin
            check("cyc_addr", bus.IcReqAddr, (n != 0) ? mq[0].a : bus.PcDate);
            check("cyc_epoch", 32'(bus.IcReqEpoch), 32'((n != 0) ? mq[0].e : m_ep));
        end
    end

    task automatic cyc(input bit pa, input logic [31:0] pd, input bit fl, input bit rdy);
        @(posedge Clk);
        #1;
        bus.PcAble     = pa;
        bus.PcDate     = pd;
        bus.QueFlush   = fl;
        bus.IcReqReady = rdy;
    endtask

    task automatic neg();
        @(negedge Clk);
    endtask

    logic [31:0] base;

    initial begin
        Rest           = 1'b0;
        bus.PcAble     = 1'b0;
        bus.PcDate     = '0;
        bus.QueFlush   = 1'b0;
        bus.IcReqReady = 1'b0;
        base           = 32'h1c00_0000;

        neg();
        check("rst_valid", 32'(bus.IcReqValid), 32'd0);
        check("rst_count", 32'(bus.QueCount), 32'd0);
        check("rst_stop", 32'(bus.QueStop), 32'd0);
        check("rst_addr", bus.IcReqAddr, 32'd0);
        @(posedge Clk);
        #1 Rest = 1'b1;

        // Fill with ICache stalled
        for (int i = 0; i < 4; i++) cyc(1'b1, base + 32'(4 * i), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        neg();
        check("fill_stop", 32'(bus.QueStop), 32'd1);
        check("fill_count", 32'(bus.QueCount), 32'd4);
        check("fill_addr", bus.IcReqAddr, 32'h1c00_0000);
        check("model_fill", 32'(mq.size()), 32'd4);

        // Drain in order
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, '0, 1'b0, 1'b1);
            neg();
            check("drain_addr", bus.IcReqAddr, base + 32'(4 * i));
            if (i == 0) check("drain_stop0", 32'(bus.QueStop), 32'd1);
            if (i == 1) check("drain_stop1", 32'(bus.QueStop), 32'd0);
        end
        cyc(1'b0, '0, 1'b0, 1'b0);
        neg();
        check("drained_valid", 32'(bus.IcReqValid), 32'd0);

        // Full queue with accept while the PC generator holds the next PC
        for (int i = 0; i < 4; i++) cyc(1'b1, base + 32'(4 * i), 1'b0, 1'b0);
        cyc(1'b1, 32'h1c00_0010, 1'b0, 1'b1);
        neg();
        check("sim_addr0", bus.IcReqAddr, 32'h1c00_0000);
        check("sim_cnt0", 32'(bus.QueCount), 32'd4);
        cyc(1'b1, 32'h1c00_0010, 1'b0, 1'b1);
        neg();
        check("sim_addr1", bus.IcReqAddr, 32'h1c00_0004);
        check("sim_cnt1", 32'(bus.QueCount), 32'd3);
        for (int i = 2; i < 5; i++) begin
            cyc(1'b0, '0, 1'b0, 1'b1);
            neg();
            check("sim_addr", bus.IcReqAddr, base + 32'(4 * i));
            check("sim_cnt", 32'(bus.QueCount), 32'(5 - i));
        end
        cyc(1'b0, '0, 1'b0, 1'b0);
        neg();
        check("sim_empty", 32'(bus.QueCount), 32'd0);

        // Flush with 3 queued, accept and new PC in the same cycle
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h1c00_0020 + 32'(4 * i), 1'b0, 1'b0);
        cyc(1'b1, 32'h1c00_00f0, 1'b1, 1'b1);
        neg();
        check("fl_addr", bus.IcReqAddr, 32'h1c00_0020);
        check("fl_epoch", 32'(bus.IcReqEpoch), 32'd0);
        check("fl_cnt", 32'(bus.QueCount), 32'd3);
        cyc(1'b0, '0, 1'b0, 1'b0);
        neg();
        check("post_fl_cnt", 32'(bus.QueCount), 32'd0);
        check("post_fl_valid", 32'(bus.IcReqValid), 32'd0);
        check("model_ep", 32'(m_ep), 32'd1);
        cyc(1'b1, 32'h1c00_0100, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1);
        neg();
        check("newep_valid", 32'(bus.IcReqValid), 32'd1);
        check("newep_addr", bus.IcReqAddr, 32'h1c00_0100);
        check("newep_epoch", 32'(bus.IcReqEpoch), 32'd1);
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Empty queue, PC presented with ICache ready
        cyc(1'b1, 32'h1c00_0200, 1'b0, 1'b1);
        neg();
`ifdef FETCH_REQ_BYPASS_EN
        check("byp_valid", 32'(bus.IcReqValid), 32'd1);
        check("byp_addr", bus.IcReqAddr, 32'h1c00_0200);
        check("byp_epoch", 32'(bus.IcReqEpoch), 32'd1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        neg();
        check("byp_cnt", 32'(bus.QueCount), 32'd0);
        check("byp_after_valid", 32'(bus.IcReqValid), 32'd0);
`else
        check("nobyp_valid", 32'(bus.IcReqValid), 32'd0);
        cyc(1'b0, '0, 1'b0, 1'b1);
        neg();
        check("nobyp_valid1", 32'(bus.IcReqValid), 32'd1);
        check("nobyp_addr1", bus.IcReqAddr, 32'h1c00_0200);
        check("nobyp_cnt1", 32'(bus.QueCount), 32'd1);
`endif
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Async reset with 3 entries queued and epoch=1
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h1c00_0030 + 32'(4 * i), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        neg();
        check("pre_rst_cnt", 32'(bus.QueCount), 32'd3);
        #3 Rest = 1'b0;
        #1;
        check("arst_valid", 32'(bus.IcReqValid), 32'd0);
        check("arst_count", 32'(bus.QueCount), 32'd0);
        check("arst_stop", 32'(bus.QueStop), 32'd0);
        @(posedge Clk);
        #1 Rest = 1'b1;
        cyc(1'b1, 32'h1c00_0300, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1);
        neg();
        check("rst_ep_valid", 32'(bus.IcReqValid), 32'd1);
        check("rst_ep_addr", bus.IcReqAddr, 32'h1c00_0300);
        check("rst_ep_epoch", 32'(bus.IcReqEpoch), 32'd0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        neg();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
